spi_reg_arbiter: RTL and testbench



---
 rtl/spi_reg_arbiter.sv | 120 ++++++++++++
 tb/tb_spi_reg_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: owns the five 8-bit configuration registers.
// After reset it loads the parameterised defaults, one register per clock.
// It then accepts writes from two valid/ready ports and resolves collisions
// round-robin. A write to an address of 5 or more changes no register and
// produces a one-cycle error pulse on the port that made it.
module spi_reg_arbiter #(
    parameter logic [7:0] DEF0 = 8'h00,
    parameter logic [7:0] DEF1 = 8'h00,
    parameter logic [7:0] DEF2 = 8'h00,
    parameter logic [7:0] DEF3 = 8'h00,
    parameter logic [7:0] DEF4 = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ready,
    output logic       a_err,
    input  logic       b_valid,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       b_err,
    output logic       boot_busy,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [7:0] reg3,
    output logic [7:0] reg4,
    output logic [7:0] reg5
);

    localparam int NREG = 5;
    localparam logic [NREG-1:0][7:0] DEFS = {DEF4, DEF3, DEF2, DEF1, DEF0};

    typedef enum logic {BOOT, RUN} state_e;

    state_e                 state_q;
    logic [2:0]             idx_q;
    logic [NREG-1:0][7:0]   regs_q, regs_d;
    logic                   last_b_q;      // 1: last grant went to port B
    logic                   a_err_q, b_err_q;
    logic                   boot_busy_q;

    logic grant_a, grant_b;
    logic a_xfer, b_xfer;
    logic a_ok, b_ok;

    // Round-robin grant: a lone requester always wins; on a collision the
    // port that did not win last time is granted. last_b resets to B, so A
    // wins the first collision.
    always_comb begin
        grant_a = a_valid & (~b_valid | last_b_q);
        grant_b = b_valid & ~grant_a;
        a_ready = (state_q == RUN) & grant_a;
        b_ready = (state_q == RUN) & grant_b;
        a_xfer  = a_valid & a_ready;
        b_xfer  = b_valid & b_ready;
        a_ok    = a_addr < 7'd5;
        b_ok    = b_addr < 7'd5;
    end

    // Next register file: a boot load or at most one granted, in-range write.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (state_q == BOOT) begin
                if (idx_q == 3'(i)) regs_d[i] = DEFS[i];
            end else if (a_xfer && a_ok && a_addr == 7'(i)) begin
                regs_d[i] = a_data;
            end else if (b_xfer && b_ok && b_addr == 7'(i)) begin
                regs_d[i] = b_data;
            end
        end
    end

    // Boot/run control, grant history and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            idx_q       <= 3'd0;
            regs_q      <= '0;
            last_b_q    <= 1'b1;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
            boot_busy_q <= 1'b1;
        end else begin
            regs_q <= regs_d;
            case (state_q)
                BOOT: begin
                    a_err_q <= 1'b0;
                    b_err_q <= 1'b0;
                    if (idx_q == 3'd4) begin
                        state_q     <= RUN;
                        boot_busy_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                RUN: begin
                    a_err_q <= a_xfer & ~a_ok;
                    b_err_q <= b_xfer & ~b_ok;
                    if (a_xfer)      last_b_q <= 1'b0;
                    else if (b_xfer) last_b_q <= 1'b1;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign boot_busy = boot_busy_q;
    assign reg1      = regs_q[0];
    assign reg2      = regs_q[1];
    assign reg3      = regs_q[2];
    assign reg4      = regs_q[3];
    assign reg5      = regs_q[4];

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Bench for spi_reg_arbiter. A behavioural model of the registers, the
// round-robin grant and the error pulses runs alongside the DUT.
module tb_spi_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 0, b_valid = 0;
    logic [6:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_data = 0, b_data = 0;
    logic       a_ready, b_ready, a_err, b_err, boot_busy;
    logic [7:0] reg1, reg2, reg3, reg4, reg5;

    spi_reg_arbiter #(
        .DEF0(8'h11), .DEF1(8'h22), .DEF2(8'h33), .DEF3(8'h44), .DEF4(8'h55)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .a_ready(a_ready), .a_err(a_err),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .b_ready(b_ready), .b_err(b_err),
        .boot_busy(boot_busy),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] defs [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] m_reg [5];
    int         m_boot_left;   // boot edges still to come
    logic       m_last_b;
    logic       m_aerr, m_berr;
    logic       e_ar, e_br;    // expected ready this cycle
    logic       got_ar, got_br;

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        m_boot_left = 5;
        m_last_b = 1'b1;
        m_aerr = 1'b0;
        m_berr = 1'b0;
    endfunction

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return reg1;
            1: return reg2;
            2: return reg3;
            3: return reg4;
            default: return reg5;
        endcase
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s reg%0d", tag, i + 1), dut_reg(i), m_reg[i]);
        check({tag, " a_err"}, a_err, m_aerr);
        check({tag, " b_err"}, b_err, m_berr);
        check({tag, " boot_busy"}, boot_busy, m_boot_left > 0);
    endtask

    // One clock: entered at posedge+1 (or later, before the next edge).
    task automatic cycle(input logic av, input logic [6:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [6:0] ba, input logic [7:0] bd,
                         input string tag);
        logic busy;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #3;
        busy = m_boot_left > 0;
        e_ar = !busy && av && (!bv || m_last_b);
        e_br = !busy && bv && !e_ar;
        got_ar = a_ready;
        got_br = b_ready;
        check({tag, " a_ready"}, got_ar, e_ar);
        check({tag, " b_ready"}, got_br, e_br);
        @(posedge clk);
        m_aerr = 1'b0;
        m_berr = 1'b0;
        if (busy) begin
            m_reg[5 - m_boot_left] = defs[5 - m_boot_left];
            m_boot_left--;
        end else if (e_ar) begin
            if (aa < 5) m_reg[aa] = ad; else m_aerr = 1'b1;
            m_last_b = 1'b0;
        end else if (e_br) begin
            if (ba < 5) m_reg[ba] = bd; else m_berr = 1'b1;
            m_last_b = 1'b1;
        end
        #1;
        check_state(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic av; logic [6:0] aa; logic [7:0] ad;
        logic bv; logic [6:0] ba; logic [7:0] bd;
        logic ar; logic br; logic aerr; logic berr;
        int   ridx; logic [7:0] rval;
    } vec_t;

    vec_t vt [13];

    initial begin
        // collision run continuing from boot (A granted first during boot exit)
        vt[0]  = '{1, 7'd0, 8'h01, 1, 7'd1, 8'h81, 1, 0, 0, 0, 0, 8'h01};
        vt[1]  = '{1, 7'd0, 8'h02, 1, 7'd1, 8'h81, 0, 1, 0, 0, 1, 8'h81};
        vt[2]  = '{1, 7'd0, 8'h02, 1, 7'd1, 8'h82, 1, 0, 0, 0, 0, 8'h02};
        vt[3]  = '{1, 7'd0, 8'h03, 1, 7'd1, 8'h82, 0, 1, 0, 0, 1, 8'h82};
        // single write
        vt[4]  = '{1, 7'd2, 8'hA5, 0, 7'd0, 8'h00, 1, 0, 0, 0, 2, 8'hA5};
        vt[5]  = '{0, 7'd0, 8'h00, 1, 7'd3, 8'h3C, 0, 1, 0, 0, 3, 8'h3C};
        // same-address collision
        vt[6]  = '{1, 7'd4, 8'hAA, 1, 7'd4, 8'hBB, 1, 0, 0, 0, 4, 8'hAA};
        vt[7]  = '{0, 7'd0, 8'h00, 1, 7'd4, 8'hBB, 0, 1, 0, 0, 4, 8'hBB};
        // bad addresses on B, back to back
        vt[8]  = '{0, 7'd0, 8'h00, 1, 7'd5, 8'h12, 0, 1, 0, 1, 4, 8'hBB};
        vt[9]  = '{0, 7'd0, 8'h00, 1, 7'd127, 8'h34, 0, 1, 0, 1, 0, 8'h02};
        vt[10] = '{0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0, 0, 0, 0, 0, 8'h02};
        vt[11] = '{1, 7'd5, 8'h00, 0, 7'd0, 8'h00, 1, 0, 1, 0, 1, 8'h82};
        vt[12] = '{1, 7'd1, 8'h5A, 0, 7'd0, 8'h00, 1, 0, 0, 0, 1, 8'h5A};
    end

    // ---------------- stimulus ----------------
    initial begin
        logic       rav, rbv;
        logic [6:0] raa, rba;
        logic [7:0] rad, rbd;

        model_reset();
        a_valid = 1; a_addr = 7'd0; a_data = 8'h01;
        b_valid = 1; b_addr = 7'd1; b_data = 8'h81;
        #10;
        check("reset a_ready", a_ready, 0);
        check("reset b_ready", b_ready, 0);
        check_state("reset");
        rst_n = 1'b1;
        #1;

        // boot with both ports requesting: no ready for five edges
        for (int c = 1; c <= 5; c++)
            cycle(1, 7'd0, 8'h01, 1, 7'd1, 8'h81, $sformatf("boot%0d", c));
        check("boot done busy", boot_busy, 0);
        check("boot reg5", reg5, 8'h55);

        // table-driven directed sequences
        for (int i = 0; i < 13; i++) begin
            cycle(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd,
                  $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl a_ready", i), got_ar, vt[i].ar);
            check($sformatf("vec%0d tbl b_ready", i), got_br, vt[i].br);
            check($sformatf("vec%0d tbl a_err", i), a_err, vt[i].aerr);
            check($sformatf("vec%0d tbl b_err", i), b_err, vt[i].berr);
            check($sformatf("vec%0d tbl reg", i), dut_reg(vt[i].ridx), vt[i].rval);
        end

        // randomized traffic; a waiting requester holds its request
        rav = 0; rbv = 0; raa = 0; rba = 0; rad = 0; rbd = 0;
        for (int c = 0; c < 300; c++) begin
            if (!(rav && !e_ar) || $urandom_range(0, 15) == 0) begin
                rav = $urandom_range(0, 2) != 0;
                raa = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127))
                                                  : 7'($urandom_range(0, 5));
                rad = 8'($urandom);
            end
            if (!(rbv && !e_br) || $urandom_range(0, 15) == 0) begin
                rbv = $urandom_range(0, 2) != 0;
                rba = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127))
                                                  : 7'($urandom_range(0, 5));
                rbd = 8'($urandom);
            end
            cycle(rav, raa, rad, rbv, rba, rbd, $sformatf("rnd%0d", c));
        end

        // reset asserted mid-transfer: A writes FF to address 0
        a_valid = 1; a_addr = 7'd0; a_data = 8'hFF;
        b_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst a_ready", a_ready, 0);
        check_state("midrst");
        @(posedge clk);
        #1;
        check_state("midrst held");
        #3;
        rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 5; c++)
            cycle(1, 7'd0, 8'hFF, 0, 7'd0, 8'h00, $sformatf("reboot%0d", c));
        check("reboot reg1", reg1, 8'h11);
        check("reboot reg4", reg4, 8'h44);
        cycle(1, 7'd0, 8'hFF, 0, 7'd0, 8'h00, "post reboot write");
        check("post reboot reg1", reg1, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
